fft_rx_framer: RTL and testbench
================================

FFT_RX_FRAMER -- requirements
Module: fft_rx_framer

Interface
REQ-001 Parameter DATA_W, 32, sample width (16b I / 16b Q packed).
REQ-002 Parameter FRAME_LEN, 1024, samples per FFT frame (power of two).
REQ-003 Parameter SKID_DEPTH, 8, skid buffer entries (power of two, >= 8).
REQ-004 Parameter CFG_WORD, 16'h0001, FFT config word (forward transform, default scaling).
REQ-005 clk  in  1  clock; resetn  in  1  reset, synchronous, active-low.
REQ-006 fifo_dout  in  DATA_W  sample from pre-FFT FIFO.
REQ-007 fifo_valid  in  1  fifo_dout valid this cycle.
REQ-008 fft_ready  out  1  to FIFO read controller: reads permitted.
REQ-009 m_axis_config_tdata  out  16  FFT config word.
REQ-010 m_axis_config_tvalid  out  1; m_axis_config_tready  in  1.
REQ-011 m_axis_data_tdata  out  DATA_W; m_axis_data_tvalid  out  1; m_axis_data_tlast  out  1; m_axis_data_tready  in  1.
REQ-012 frame_done  out  1  one-cycle pulse when the last sample of a frame is accepted.
REQ-013 overflow  out  1  sticky error: sample arrived while skid buffer full.

Function
REQ-014 FSM states: CFG, STREAM.
REQ-015 CFG: m_axis_config_tvalid=1, tdata=CFG_WORD; on tvalid&&tready -> STREAM next cycle, tvalid drops.
REQ-016 STREAM: config tvalid held 0; state is final until reset.
REQ-017 Skid buffer: circular, SKID_DEPTH entries, occupancy count 0..SKID_DEPTH.
REQ-018 Write: fifo_valid=1 and count<SKID_DEPTH -> store fifo_dout; fifo_valid is honoured in both states.
REQ-019 fifo_valid=1 with count==SKID_DEPTH -> sample dropped, overflow set, held until reset.
REQ-020 m_axis_data_tvalid = (state==STREAM) && count>0; tdata = head entry, combinational from buffer.
REQ-021 Pop on tvalid&&tready; simultaneous push and pop leaves count unchanged.
REQ-022 Push into empty buffer: sample presented on tvalid the next cycle (1-cycle latency).
REQ-023 fft_ready registered: next value = (count_next <= SKID_DEPTH/2 - 1), i.e. <=3 for depth 8.
REQ-024 Fill across fft_ready deassertion (up to 3 in-flight reads) shall never overflow with depth 8.
REQ-025 fft_ready is forced 0 in CFG.
REQ-026 Sample counter: log2(FRAME_LEN) bits, increments per accepted output beat, wraps to 0 after FRAME_LEN-1.
REQ-027 m_axis_data_tlast = tvalid && sample counter==FRAME_LEN-1.
REQ-028 frame_done pulses in the cycle after the tlast beat is accepted.
REQ-029 tdata/tvalid/tlast held stable while tvalid=1 and tready=0.
REQ-030 Pointers wrap modulo SKID_DEPTH with no bubble.

Reset
REQ-031 resetn=0 at a clock edge: state=CFG, count=0, pointers=0, sample counter=0, overflow=0, frame_done=0, fft_ready=0, m_axis_data_tvalid=0; config tvalid=1 from the first cycle after release.
REQ-032 Reset mid-frame discards buffered samples and the partial frame; no tlast is issued for it.

Verification
REQ-033 Release reset, config tready=1 at cycle 3 -> config handshake once with tdata=16'h0001, STREAM next cycle, fft_ready=1 the following cycle.
REQ-034 2048 contiguous samples (value=index), tready=1 -> 2048 output beats in order, tlast on indices 1023 and 2047, two frame_done pulses, overflow=0.
REQ-035 Stream with random tready (50%) and controller model (2-cycle rd-to-valid latency) -> no overflow, order preserved, count never exceeds 8.
REQ-036 Fill buffer to 8 with tready=0, then drive fifo_valid=1 -> sample dropped, overflow=1 held until reset.
REQ-037 Samples arrive while in CFG (config tready=0) -> buffered, data tvalid=0 until config accepted, then emitted in order.
REQ-038 resetn low after sample 500 of a frame -> all outputs at reset values; next frame's tlast after exactly 1024 new beats.

Source files
------------

// File: rtl/fft_rx_framer.sv
// Pre-FFT receive framer: sends one FFT config word, then streams FIFO samples
// through a small skid buffer onto AXI-Stream, marking frame boundaries with tlast.
module fft_rx_framer #(
    parameter int          DATA_W     = 32,
    parameter int          FRAME_LEN  = 1024,
    parameter int          SKID_DEPTH = 8,
    parameter logic [15:0] CFG_WORD   = 16'h0001
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_valid,
    output logic              fft_ready,
    output logic [15:0]       m_axis_config_tdata,
    output logic              m_axis_config_tvalid,
    input  logic              m_axis_config_tready,
    output logic [DATA_W-1:0] m_axis_data_tdata,
    output logic              m_axis_data_tvalid,
    output logic              m_axis_data_tlast,
    input  logic              m_axis_data_tready,
    output logic              frame_done,
    output logic              overflow
);

    localparam int PTR_W = $clog2(SKID_DEPTH);
    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W + 1)'(SKID_DEPTH);
    localparam logic [PTR_W:0]   READY_LIM = (PTR_W + 1)'(SKID_DEPTH / 2 - 1);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {
        CFG,
        STREAM
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] mem [SKID_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic [PTR_W:0]    count_next;
    logic [CNT_W-1:0]  sample_cnt;
    logic              push;
    logic              pop;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= CFG;
        end else begin
            state <= state_next;
        end
    end

    // STREAM is terminal; only reset returns the framer to CFG.
    always_comb begin
        state_next           = state;
        m_axis_config_tvalid = 1'b0;
        case (state)
            CFG: begin
                m_axis_config_tvalid = 1'b1;
                if (m_axis_config_tready) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                state_next = STREAM;
            end
            default: begin
                state_next = CFG;
            end
        endcase
    end

    assign m_axis_config_tdata = CFG_WORD;

    assign push               = fifo_valid && (count < DEPTH_C);
    assign m_axis_data_tvalid = (state == STREAM) && (count != '0);
    assign pop                = m_axis_data_tvalid && m_axis_data_tready;
    assign m_axis_data_tdata  = mem[rd_ptr];
    assign m_axis_data_tlast  = m_axis_data_tvalid && (sample_cnt == LAST_IDX);

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= fifo_dout;
        end
    end

    // Pointers and the frame counter are power-of-two wide, so they wrap for free.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            sample_cnt <= '0;
            frame_done <= 1'b0;
            fft_ready  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            count      <= count_next;
            frame_done <= pop && m_axis_data_tlast;
            fft_ready  <= (state == STREAM) && (count_next <= READY_LIM);
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                sample_cnt <= sample_cnt + 1'b1;
            end
            if (fifo_valid && (count == DEPTH_C)) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft_rx_framer.sv
// Directed bench for fft_rx_framer: a hand-computed vector table, then
// multi-cycle sequences checked against a small occupancy/frame model.
module tb_fft_rx_framer;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] fifo_dout;
    logic        fifo_valid;
    logic        fft_ready;
    logic [15:0] m_axis_config_tdata;
    logic        m_axis_config_tvalid;
    logic        m_axis_config_tready;
    logic [31:0] m_axis_data_tdata;
    logic        m_axis_data_tvalid;
    logic        m_axis_data_tlast;
    logic        m_axis_data_tready;
    logic        frame_done;
    logic        overflow;

    always #5 clk = ~clk;

    fft_rx_framer dut (
        .clk                  (clk),
        .resetn               (resetn),
        .fifo_dout            (fifo_dout),
        .fifo_valid           (fifo_valid),
        .fft_ready            (fft_ready),
        .m_axis_config_tdata  (m_axis_config_tdata),
        .m_axis_config_tvalid (m_axis_config_tvalid),
        .m_axis_config_tready (m_axis_config_tready),
        .m_axis_data_tdata    (m_axis_data_tdata),
        .m_axis_data_tvalid   (m_axis_data_tvalid),
        .m_axis_data_tlast    (m_axis_data_tlast),
        .m_axis_data_tready   (m_axis_data_tready),
        .frame_done           (frame_done),
        .overflow             (overflow)
    );

    typedef struct {
        logic        rst_n;
        logic        fv;
        logic [31:0] dout;
        logic        cfg_rdy;
        logic        d_rdy;
        logic        e_cfg_v;
        logic        e_dv;
        logic [31:0] e_data;
        logic        e_last;
        logic        e_fr;
        logic        e_fd;
        logic        e_ov;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic        m_stream;
    int          m_count;
    int          m_beat;
    logic        m_fr;
    logic        m_fd;
    logic        m_ov;
    logic [31:0] m_q[$];
    int          n_beats;
    int          n_tlast;
    int          n_fd;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_stream = 1'b0;
        m_count  = 0;
        m_beat   = 0;
        m_fr     = 1'b0;
        m_fd     = 1'b0;
        m_ov     = 1'b0;
        m_q.delete();
    endtask

    task automatic run_cycle(input logic rst, input logic fv, input logic [31:0] dout,
                             input logic cr, input logic dr);
        logic exp_dv;
        logic exp_last;
        logic push;
        logic pop;
        resetn               = rst;
        fifo_valid           = fv;
        fifo_dout            = dout;
        m_axis_config_tready = cr;
        m_axis_data_tready   = dr;
        #1;
        exp_dv   = m_stream && (m_count > 0);
        exp_last = exp_dv && (m_beat == 1023);
        check_output("cfg_tvalid", m_axis_config_tvalid, !m_stream);
        if (!m_stream) check_output("cfg_tdata", m_axis_config_tdata, 32'h0001);
        check_output("data_tvalid", m_axis_data_tvalid, exp_dv);
        if (exp_dv) begin
            check_output("tdata", m_axis_data_tdata, m_q[0]);
            check_output("tlast", m_axis_data_tlast, exp_last);
        end
        check_output("fft_ready", fft_ready, m_fr);
        check_output("frame_done", frame_done, m_fd);
        check_output("overflow", overflow, m_ov);
        if (m_axis_data_tvalid && dr && m_axis_data_tlast) n_tlast++;
        if (frame_done) n_fd++;
        if (!rst) begin
            model_reset();
        end else begin
            push = fv && (m_count < 8);
            pop  = exp_dv && dr;
            m_fd = pop && exp_last;
            if (fv && (m_count == 8)) m_ov = 1'b1;
            if (pop) begin
                void'(m_q.pop_front());
                m_beat = (m_beat + 1) % 1024;
                m_count--;
                n_beats++;
            end
            if (push) begin
                m_q.push_back(dout);
                m_count++;
            end
            m_fr     = m_stream && (m_count <= 3);
            m_stream = m_stream || cr;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        resetn     = 1'b0;
        fifo_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        run_cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic handshake();
        run_cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (m_count > 0 && k < budget) begin
            run_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
            k++;
        end
        if (m_count > 0) check_output("drain_timeout", 32'(m_count), 32'h0);
        run_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic apply_stimulus();
        vec_t vecs[12];
        vecs[0]  = '{1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 32'hA000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 32'hA000_0001, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'hA000_0000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'hA000_0000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'hA000_0000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 32'hA000_0002, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA000_0001, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'hA000_0002, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 32'hB000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'hB000_0000, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 12; i++) begin
            resetn               = vecs[i].rst_n;
            fifo_valid           = vecs[i].fv;
            fifo_dout            = vecs[i].dout;
            m_axis_config_tready = vecs[i].cfg_rdy;
            m_axis_data_tready   = vecs[i].d_rdy;
            #1;
            check_output($sformatf("v%0d_cfg_tvalid", i), m_axis_config_tvalid, vecs[i].e_cfg_v);
            if (vecs[i].e_cfg_v) check_output($sformatf("v%0d_cfg_tdata", i), m_axis_config_tdata, 32'h0001);
            check_output($sformatf("v%0d_data_tvalid", i), m_axis_data_tvalid, vecs[i].e_dv);
            if (vecs[i].e_dv) check_output($sformatf("v%0d_tdata", i), m_axis_data_tdata, vecs[i].e_data);
            check_output($sformatf("v%0d_tlast", i), m_axis_data_tlast, vecs[i].e_last);
            check_output($sformatf("v%0d_fft_ready", i), fft_ready, vecs[i].e_fr);
            check_output($sformatf("v%0d_frame_done", i), frame_done, vecs[i].e_fd);
            check_output($sformatf("v%0d_overflow", i), overflow, vecs[i].e_ov);
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [1:0] pipe;
        logic       rd;
        logic       fv;
        int         issued;
        int         sent;
        int         cyc;
        int         t0;

        resetn               = 1'b0;
        fifo_valid           = 1'b0;
        fifo_dout            = '0;
        m_axis_config_tready = 1'b0;
        m_axis_data_tready   = 1'b0;
        n_beats = 0;
        n_tlast = 0;
        n_fd    = 0;
        model_reset();
        repeat (2) @(negedge clk);

        $display("[TB] vector table");
        apply_stimulus();

        $display("[TB] config handshake at cycle 3");
        do_reset();
        for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        handshake();
        for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

        $display("[TB] two contiguous frames");
        do_reset();
        handshake();
        n_beats = 0; n_tlast = 0; n_fd = 0;
        for (int i = 0; i < 2048; i++) run_cycle(1'b1, 1'b1, 32'(i), 1'b0, 1'b1);
        drain(20);
        check_output("frames_beats", 32'(n_beats), 32'd2048);
        check_output("frames_tlast", 32'(n_tlast), 32'd2);
        check_output("frames_done", 32'(n_fd), 32'd2);

        $display("[TB] random tready with read controller");
        do_reset();
        handshake();
        n_beats = 0;
        pipe = 2'b00; issued = 0; sent = 0; cyc = 0;
        while (n_beats < 600 && cyc < 8000) begin
            rd   = fft_ready && (issued < 600);
            fv   = pipe[1];
            pipe = {pipe[0], rd};
            if (rd) issued++;
            run_cycle(1'b1, fv, 32'(sent), 1'b0, 1'($urandom_range(0, 1)));
            if (fv) sent++;
            cyc++;
        end
        check_output("random_beats", 32'(n_beats), 32'd600);

        $display("[TB] overflow on full buffer");
        do_reset();
        handshake();
        for (int i = 0; i < 8; i++) run_cycle(1'b1, 1'b1, 32'(100 + i), 1'b0, 1'b0);
        run_cycle(1'b1, 1'b1, 32'd999, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        drain(20);
        run_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        do_reset();

        $display("[TB] samples buffered during config");
        for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b1, 32'(200 + i), 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) run_cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        run_cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        drain(20);

        $display("[TB] reset mid-frame");
        do_reset();
        handshake();
        for (int i = 0; i < 500; i++) run_cycle(1'b1, 1'b1, 32'(i), 1'b0, 1'b1);
        do_reset();
        handshake();
        t0 = n_tlast;
        n_beats = 0;
        for (int i = 0; i < 1024; i++) run_cycle(1'b1, 1'b1, 32'(5000 + i), 1'b0, 1'b1);
        drain(20);
        check_output("refill_beats", 32'(n_beats), 32'd1024);
        check_output("refill_tlast", 32'(n_tlast - t0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
